keypad_emulator: RTL

Behavioural stand-in for a physical 4x4 matrix keypad, synthesisable for hardware-in-the-loop checks of the scanner path. It sits on the opposite side of the row/column interface from the keypad scanner: it accepts key codes from a test controller into a small FIFO and replays each one as a timed press and release. While a key is closed, it pulls the matching active-low column low whenever the scanner drives that key's row low. With `row` and `col` wired to the scanner's row output and column input, the existing scan, decode and storage chain runs unmodified.

---
 rtl/keypad_emulator.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/keypad_emulator.sv
`default_nettype none
// ============================================================================
//  Module      : keypad_emulator
//  Description : Behavioural 4x4 matrix keypad for hardware-in-the-loop tests.
//                Key codes are queued in a small FIFO and replayed as timed
//                press/release events.  While a key is closed, its active-low
//                column follows its active-low row combinationally.
//                Optional contact chatter: define KEYPAD_EMU_BOUNCE_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module keypad_emulator #(
    parameter int HOLD_CYCLES   = 500,
    parameter int GAP_CYCLES    = 300,
    parameter int DEPTH         = 4,
    parameter int BOUNCE_CYCLES = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    output logic       key_ready,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic       pressed,
    output logic [3:0] active_code,
    output logic       busy
);

    localparam int c_max_cyc = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int c_cnt_w   = (c_max_cyc > 1) ? $clog2(c_max_cyc) : 1;
    localparam int c_ptr_w   = $clog2(DEPTH);

    localparam logic [c_cnt_w-1:0] c_hold_load = c_cnt_w'(HOLD_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_gap_load  = c_cnt_w'(GAP_CYCLES - 1);
    localparam logic [c_ptr_w:0]   c_full      = (c_ptr_w + 1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRESS = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_next_state;
    logic [c_cnt_w-1:0]   r_counter;
    logic [c_cnt_w-1:0]   w_next_counter;
    logic [3:0]           w_next_code;
    logic                 w_pop;
    logic                 w_push;

    logic [3:0]           r_mem [DEPTH];
    logic [c_ptr_w-1:0]   r_wr_ptr;
    logic [c_ptr_w-1:0]   r_rd_ptr;
    logic [c_ptr_w:0]     r_count;

    logic [1:0]           w_key_row;
    logic [1:0]           w_key_col;

    // Ready depends on the registered count only, so a pop never frees a slot early.
    assign key_ready = (r_count != c_full);
    assign w_push    = key_valid && key_ready;
    assign busy      = (r_count != '0) || (r_state != ST_IDLE);

    // FIFO storage; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= key_code;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (c_ptr_w + 1)'(1);
                2'b01:   r_count <= r_count - (c_ptr_w + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Press/gap sequencer state, phase counter and the key being replayed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_counter   <= '0;
            active_code <= 4'h0;
        end else begin
            r_state     <= w_next_state;
            r_counter   <= w_next_counter;
            active_code <= w_next_code;
        end
    end

    // Next-state logic: IDLE pops a key, PRESS and GAP count down to zero.
    always_comb begin
        w_next_state   = r_state;
        w_next_counter = r_counter;
        w_next_code    = active_code;
        w_pop          = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_count != '0) begin
                    w_pop          = 1'b1;
                    w_next_code    = r_mem[r_rd_ptr];
                    w_next_counter = c_hold_load;
                    w_next_state   = ST_PRESS;
                end
            end
            ST_PRESS: begin
                if (r_counter == '0) begin
                    w_next_counter = c_gap_load;
                    w_next_state   = ST_GAP;
                end else begin
                    w_next_counter = r_counter - c_cnt_w'(1);
                end
            end
            ST_GAP: begin
                if (r_counter == '0) begin
                    w_next_state = ST_IDLE;
                end else begin
                    w_next_counter = r_counter - c_cnt_w'(1);
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

`ifdef KEYPAD_EMU_BOUNCE_EN
    localparam logic [c_cnt_w-1:0] c_bounce = c_cnt_w'(BOUNCE_CYCLES);
    logic [c_cnt_w-1:0] w_elapsed;

    // Contact chatters at the start of each phase: closed-first in PRESS, open-first in GAP.
    always_comb begin
        w_elapsed = '0;
        pressed   = 1'b0;
        if (r_state == ST_PRESS) begin
            w_elapsed = c_hold_load - r_counter;
            pressed   = (w_elapsed < c_bounce) ? ~w_elapsed[0] : 1'b1;
        end else if (r_state == ST_GAP) begin
            w_elapsed = c_gap_load - r_counter;
            pressed   = (w_elapsed < c_bounce) ? w_elapsed[0] : 1'b0;
        end
    end
`else
    logic [31:0] w_unused_bounce;
    assign w_unused_bounce = BOUNCE_CYCLES;

    // Clean contact: closed for the whole PRESS phase.
    always_comb begin
        pressed = (r_state == ST_PRESS);
    end
`endif

    // Key code to matrix position (row, column).
    always_comb begin
        w_key_row = 2'd0;
        w_key_col = 2'd0;
        case (active_code)
            4'h1: begin w_key_row = 2'd0; w_key_col = 2'd0; end
            4'h2: begin w_key_row = 2'd0; w_key_col = 2'd1; end
            4'h3: begin w_key_row = 2'd0; w_key_col = 2'd2; end
            4'hA: begin w_key_row = 2'd0; w_key_col = 2'd3; end
            4'h4: begin w_key_row = 2'd1; w_key_col = 2'd0; end
            4'h5: begin w_key_row = 2'd1; w_key_col = 2'd1; end
            4'h6: begin w_key_row = 2'd1; w_key_col = 2'd2; end
            4'hB: begin w_key_row = 2'd1; w_key_col = 2'd3; end
            4'h7: begin w_key_row = 2'd2; w_key_col = 2'd0; end
            4'h8: begin w_key_row = 2'd2; w_key_col = 2'd1; end
            4'h9: begin w_key_row = 2'd2; w_key_col = 2'd2; end
            4'hC: begin w_key_row = 2'd2; w_key_col = 2'd3; end
            4'hE: begin w_key_row = 2'd3; w_key_col = 2'd0; end
            4'h0: begin w_key_row = 2'd3; w_key_col = 2'd1; end
            4'hF: begin w_key_row = 2'd3; w_key_col = 2'd2; end
            4'hD: begin w_key_row = 2'd3; w_key_col = 2'd3; end
            default: begin w_key_row = 2'd0; w_key_col = 2'd0; end
        endcase
    end

    // Switch model: only the closed key's column follows its row, with no latency.
    always_comb begin
        col = 4'hF;
        if (pressed && !row[w_key_row]) begin
            col[w_key_col] = 1'b0;
        end
    end

endmodule
`default_nettype wire
